fir_avg_decim: RTL



---
 rtl/fir_pkg.sv | 29 ++
 rtl/fir_avg_decim_if.sv | 25 ++
 rtl/fir_decim_fifo.sv | 65 ++++++
 rtl/fir_avg_decim.sv | 104 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and the output saturation helper for the FIR output stage and its models.
package fir_pkg;

   localparam int unsigned FIR_IN_W  = 24;
   localparam int unsigned FIR_OUT_W = 16;

   typedef logic signed [FIR_OUT_W-1:0] fir_out_t;

   typedef struct packed {
      logic     sat;
      fir_out_t val;
   } sat_res_t;

   // A value fits the output exactly when every bit above the output sign bit equals that sign bit.
   function automatic sat_res_t sat_to_out(input logic signed [FIR_IN_W:0] s);
      sat_res_t                     r;
      logic [FIR_IN_W-FIR_OUT_W+1:0] hi;
      hi    = s[FIR_IN_W:FIR_OUT_W-1];
      r.sat = !((&hi) || !(|hi));
      if (!r.sat)
         r.val = s[FIR_OUT_W-1:0];
      else if (s[FIR_IN_W])
         r.val = {1'b1, {(FIR_OUT_W-1){1'b0}}};
      else
         r.val = {1'b0, {(FIR_OUT_W-1){1'b1}}};
      return r;
   endfunction

endpackage

// File: rtl/fir_avg_decim_if.sv
// Sample-in / stream-out bundle of the FIR output stage; slave side is the stage itself.
interface fir_avg_decim_if
   import fir_pkg::*;
#(
   parameter int unsigned IN_W  = FIR_IN_W,
   parameter int unsigned OUT_W = FIR_OUT_W
);
   logic                    in_valid;
   logic signed [IN_W-1:0]  din;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] dout;
   logic                    sat_pulse;
   logic                    ovf;

   modport master (
      output in_valid, din, out_ready,
      input  out_valid, dout, sat_pulse, ovf
   );

   modport slave (
      input  in_valid, din, out_ready,
      output out_valid, dout, sat_pulse, ovf
   );
endinterface

// File: rtl/fir_decim_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata reads 0 while empty.
module fir_decim_fifo #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             wdata,
   input  logic                         pop,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH):0]       count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == CW'(DEPTH));
      rd_en = pop && !empty;
      // A push into a full FIFO is legal only when the head leaves in the same cycle.
      wr_en = push && (!full || rd_en);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en)
         rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !rd_en)
         count_d = count_q + CW'(1);
      else if (!wr_en && rd_en)
         count_d = count_q - CW'(1);

      rdata = empty ? '0 : mem_q[rd_ptr_q];
      count = count_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/fir_avg_decim.sv
// FIR output stage: decimate, shift, saturate to OUT_W, buffer in a FWFT FIFO.
// FIR_DECIM_ROUND_EN selects round-half-up before the shift; default truncates toward -inf.
module fir_avg_decim
   import fir_pkg::*;
#(
   parameter int unsigned IN_W  = FIR_IN_W,
   parameter int unsigned OUT_W = FIR_OUT_W,
   parameter int unsigned SHIFT = 3,
   parameter int unsigned DECIM = 2,
   parameter int unsigned DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   fir_avg_decim_if.slave bus
);
   localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int unsigned CW   = $clog2(DEPTH) + 1;

   logic [PH_W-1:0]         phase_q, phase_d;
   logic                    pipe_valid_q, pipe_valid_d;
   logic                    pipe_sat_q, pipe_sat_d;
   logic signed [OUT_W-1:0] pipe_data_q, pipe_data_d;
   logic                    ovf_q, ovf_d;

   logic                    keep;
   logic signed [IN_W:0]    ext, scaled;
   logic [IN_W-OUT_W+1:0]   hi;
   logic                    clamp;
   logic signed [OUT_W-1:0] sat_val;

   logic                    push, pop, full, empty;
   logic [OUT_W-1:0]        fifo_rdata;
   logic [CW-1:0]           fifo_count;

   always_comb begin
      keep    = bus.in_valid && (phase_q == '0);
      phase_d = phase_q;
      if (bus.in_valid)
         phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + PH_W'(1);

      // One guard bit keeps the rounding add from wrapping at full-scale positive input.
      ext = {bus.din[IN_W-1], bus.din};
`ifdef FIR_DECIM_ROUND_EN
      ext = ext + ((IN_W+1)'(1) << (SHIFT - 1));
`endif
      scaled = ext >>> SHIFT;

      hi    = scaled[IN_W:OUT_W-1];
      clamp = !((&hi) || !(|hi));
      if (!clamp)
         sat_val = scaled[OUT_W-1:0];
      else if (scaled[IN_W])
         sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      else
         sat_val = {1'b0, {(OUT_W-1){1'b1}}};

      pipe_valid_d = keep;
      pipe_sat_d   = keep && clamp;
      pipe_data_d  = keep ? sat_val : pipe_data_q;

      pop   = !empty && bus.out_ready;
      push  = pipe_valid_q && (!full || pop);
      ovf_d = ovf_q || (pipe_valid_q && full && !pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= '0;
         pipe_valid_q <= 1'b0;
         pipe_sat_q   <= 1'b0;
         pipe_data_q  <= '0;
         ovf_q        <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_sat_q   <= pipe_sat_d;
         pipe_data_q  <= pipe_data_d;
         ovf_q        <= ovf_d;
      end
   end

   fir_decim_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (pipe_data_q),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign bus.out_valid = !empty;
   assign bus.dout      = fifo_rdata;
   assign bus.sat_pulse = pipe_sat_q;
   assign bus.ovf       = ovf_q;

   a_count_bound : assert property (@(posedge clk) disable iff (rst) fifo_count <= CW'(DEPTH));

endmodule
